aes_out_serializer: RTL
=======================

// Module: aes_out_serializer
// PURPOSE
//  Downstream stage of AES_top. Captures each 128-bit ciphertext block when AES_data_out_valid rises.
//  Buffers captured blocks in a small FIFO.
//  Emits each block as WORD_W-bit words, MSB word first, on a valid/ready stream to the host/bus side.
//  Flags blocks dropped because the FIFO was full.
// PARAMETERS
//  DATA_W      128  block width; must equal AES_top data width
//  WORD_W      32   output word width; DATA_W % WORD_W == 0
//  FIFO_DEPTH  2    block entries buffered; power of 2, >= 2
// PORTS
//  AES_clk             in   1       single clock, rising edge
//  AES_rst             in   1       asynchronous, active-high reset
//  AES_data_out        in   DATA_W  ciphertext from AES_top
//  AES_data_out_valid  in   1       AES_top result valid (level); capture on rising edge only
//  ser_word_out        out  WORD_W  current output word
//  ser_valid           out  1       ser_word_out valid
//  ser_ready           in   1       consumer accepts word when ser_valid & ser_ready
//  ser_last            out  1       high with the final word of a block
//  fifo_full           out  1       FIFO holds FIFO_DEPTH blocks
//  overflow            out  1       sticky: a block was dropped
//  ovf_clr             in   1       synchronous clear of overflow
// BEHAVIOUR
//  Reset values: ser_word_out=0, ser_valid=0, ser_last=0, fifo_full=0, overflow=0.
//  Internal reset values: FIFO empty, word counter=0, state=IDLE, valid_d=1.
//  Because valid_d resets to 1, a valid level held high through reset is NOT captured.
//  Capture rule:
//   - rise = AES_data_out_valid & ~valid_d, evaluated every cycle.
//   - On rise, AES_data_out is written to the FIFO at that clock edge.
//   - A valid held high for several cycles produces exactly one capture.
//  FSM states: IDLE, SEND.
//   - IDLE -> SEND when the FIFO is non-empty: pop the head into the shift register, counter=0.
//   - SEND: ser_valid=1; ser_word_out = shreg[DATA_W-1 -: WORD_W].
//   - On each handshake, shift left by WORD_W and increment the counter.
//   - ser_last = (counter == DATA_W/WORD_W-1).
//   - Handshake with ser_last: if the FIFO is non-empty, pop the next block in the same edge
//     (no bubble) and stay in SEND; otherwise go to IDLE and drop ser_valid.
//  Latency: rise seen at edge k -> FIFO write at edge k -> load at edge k+1.
//   ser_valid is high after edge k+1 (2 cycles) when the serializer is idle.
//  Stream rules:
//   - While ser_valid & ~ser_ready, ser_word_out and ser_last hold stable.
//   - ser_valid never drops before its handshake.
//  Full and overflow:
//   - A rise while full, with no pop at the same edge, drops the block and sets overflow.
//   - A rise and a pop at the same edge while full: the write is accepted and the count is unchanged.
//   - ovf_clr and a new drop at the same edge: overflow stays set (set wins).
//  FIFO pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.
//  Reset mid-block: all outputs return to reset values immediately (async).
//   Partial and buffered blocks are discarded; no word is re-emitted after release.
// STRUCTURE
//  aes_pkg: AES_BLOCK_W=128, default WORD_W, WORDS_PER_BLOCK = AES_BLOCK_W/WORD_W,
//   state enum {IDLE, SEND}.
//  Sub-module aes_block_fifo: synchronous FIFO of DATA_W entries with wr_en, rd_en, full, empty.
//   Async active-high reset on pointers only.
//  Top level holds the edge detect, FSM, shift register, counter and overflow flag.
// TESTING
//  1. Reset release with valid already high, no further rise -> no capture, ser_valid stays 0.
//  2. Single block, ser_ready=1:
//     valid rises with 128'h3925841d_02dc09fb_dc118597_196a0b32, held 5 cycles
//     -> words 3925841d, 02dc09fb, dc118597, 196a0b32 on 4 consecutive cycles.
//     ser_last on the 4th word only; exactly one block emitted.
//  3. Backpressure: same block, ser_ready toggles 1,0,0,1,...
//     -> each word held stable while stalled; order unchanged; 4 handshakes total.
//  4. Three rises 3 cycles apart with ser_ready=0, DEPTH=2:
//     -> the first is loaded into the shreg, the next two fill the FIFO (fifo_full=1), overflow=0.
//     A 4th rise -> overflow=1, and the block is absent from the output.
//  5. Back-to-back: two blocks buffered, ser_ready=1 -> 8 words with no idle cycle between blocks.
//     ovf_clr pulse -> overflow=0.
//  6. AES_rst asserted after the 2nd word of a block
//     -> ser_valid=0 immediately; after release, no words appear until a new rise.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES output serializer slice.
// AES_BLOCK_W     : width of one AES ciphertext block.
// AES_WORD_W      : default width of one serialized output word.
// WORDS_PER_BLOCK : number of output words in one block at the default width.
// ser_state_t     : serializer FSM states.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W     = 128;
  localparam int unsigned AES_WORD_W      = 32;
  localparam int unsigned WORDS_PER_BLOCK = AES_BLOCK_W / AES_WORD_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/aes_block_fifo.sv
// Synchronous FIFO that holds whole ciphertext blocks.
// i_clk/i_rst : clock, asynchronous active-high reset (pointers only)
// i_wr_en     : push i_wr_data; ignored when full, unless a read happens in the same cycle
// i_rd_en     : pop the head; ignored when empty
// o_rd_data   : current head entry, readable before the pop edge
// o_full      : DEPTH entries stored
// o_empty     : no entries stored
module aes_block_fifo #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit tells a full FIFO apart from an empty one.
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_do_rd;
  logic w_do_wr;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_rd   = i_rd_en & ~o_empty;
  // A pop in the same cycle frees the slot that the write then fills.
  assign w_do_wr   = i_wr_en & (~o_full | w_do_rd);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/aes_out_serializer.sv
// Downstream stage of AES_top: captures each ciphertext block on the rising
// edge of AES_data_out_valid, buffers blocks in a small FIFO and emits them
// MSB word first on a valid/ready stream.
// AES_clk, AES_rst        : clock, asynchronous active-high reset
// AES_data_out(_valid)    : ciphertext block and its level valid from AES_top
// ser_word_out, ser_valid : output word and its valid
// ser_ready               : consumer ready; handshake = ser_valid & ser_ready
// ser_last                : final word of a block
// fifo_full               : FIFO holds FIFO_DEPTH blocks
// overflow, ovf_clr       : sticky dropped-block flag and its synchronous clear
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W     = AES_BLOCK_W,
  parameter int unsigned WORD_W     = AES_WORD_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              AES_clk,
  input  logic              AES_rst,
  input  logic [DATA_W-1:0] AES_data_out,
  input  logic              AES_data_out_valid,
  output logic [WORD_W-1:0] ser_word_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              fifo_full,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned     WORDS    = DATA_W / WORD_W;
  localparam int unsigned     CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);
  localparam logic             ONE_WORD = (WORDS == 1);

  ser_state_t        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic              r_last;
  logic              r_valid_d;
  logic              r_ovf;

  logic              w_rise;
  logic              w_hs;
  logic              w_pop;
  logic              w_wr_en;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_head;

  // valid_d resets high so a level already asserted through reset is ignored.
  assign w_rise  = AES_data_out_valid & ~r_valid_d;
  assign w_hs    = r_valid & ser_ready;
  // Pop when idle, or on the final handshake so the next block follows with no bubble.
  assign w_pop   = ~w_fifo_empty & ((r_state == IDLE) | (w_hs & r_last));
  assign w_wr_en = w_rise & (~w_fifo_full | w_pop);

  aes_block_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (AES_clk),
    .i_rst     (AES_rst),
    .i_wr_en   (w_wr_en),
    .i_wr_data (AES_data_out),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      r_valid_d <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_valid_d <= AES_data_out_valid;
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_rise & w_fifo_full & ~w_pop) r_ovf <= 1'b1;
      else if (ovf_clr)                  r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= SEND;
            r_shreg <= w_head;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_last  <= ONE_WORD;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (r_last) begin
              if (w_pop) begin
                r_shreg <= w_head;
                r_cnt   <= '0;
                r_last  <= ONE_WORD;
              end else begin
                r_state <= IDLE;
                r_shreg <= r_shreg << WORD_W;
                r_cnt   <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
              end
            end else begin
              r_shreg <= r_shreg << WORD_W;
              r_cnt   <= r_cnt + 1'b1;
              r_last  <= ((r_cnt + 1'b1) == LAST_CNT);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ser_word_out = r_shreg[DATA_W-1 -: WORD_W];
  assign ser_valid    = r_valid;
  assign ser_last     = r_last;
  assign fifo_full    = w_fifo_full;
  assign overflow     = r_ovf;

endmodule
